operand_loader: RTL and testbench

OPERAND_LOADER -- requirements
Module: operand_loader

---
 rtl/operand_pkg.sv | 15 +
 rtl/operand_idle_timer.sv | 30 +++
 rtl/operand_loader.sv | 109 ++++++++++
 tb/tb_operand_loader.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/operand_pkg.sv
// Shared defaults and FSM state type for the operand loader.
package operand_pkg;

   localparam int OP_DATA_W         = 8;
   localparam int NUM_OPERANDS      = 3;
   localparam int OP_TIMEOUT_CYCLES = 16;

   typedef enum logic [1:0] {
      S0   = 2'd0,
      S1   = 2'd1,
      S2   = 2'd2,
      HOLD = 2'd3
   } state_e;

endpackage

// File: rtl/operand_idle_timer.sv
// Idle-cycle counter for partial frames; o_expire flags the last permitted idle cycle.
module operand_idle_timer
   import operand_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = OP_TIMEOUT_CYCLES
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_count,
   output logic o_expire
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Expiry is qualified by i_count, so a same-cycle accept always wins.
   assign o_expire = i_count && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      cnt_d = '0;
      if (i_count && !o_expire) cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

endmodule

// File: rtl/operand_loader.sv
// Assembles three upstream bytes into one operand frame and holds it until taken.
// Define OPERAND_LOADER_TIMEOUT_EN to drop partial frames after TIMEOUT_CYCLES idle cycles.
module operand_loader
   import operand_pkg::*;
#(
   parameter int DATA_W         = OP_DATA_W,
   parameter int TIMEOUT_CYCLES = OP_TIMEOUT_CYCLES
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_valid,
   output logic              o_ready,
   output logic [DATA_W-1:0] o_p0,
   output logic [DATA_W-1:0] o_p1,
   output logic [DATA_W-1:0] o_p2,
   output logic              o_valid,
   input  logic              i_ready,
   output logic              o_timeout
);

   state_e                               state_q, state_d;
   logic [NUM_OPERANDS-1:0][DATA_W-1:0]  ops_q, ops_d;
   logic                                 valid_q;
   logic                                 accept;
   logic                                 expire;

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("operand_loader: TIMEOUT_CYCLES must be at least 1");
   end

   assign o_ready = (state_q != HOLD) && !i_rst;
   assign accept  = i_valid && o_ready;

`ifdef OPERAND_LOADER_TIMEOUT_EN
   logic timeout_q;

   operand_idle_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_idle_timer (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_count  (((state_q == S1) || (state_q == S2)) && !accept),
      .o_expire (expire)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) timeout_q <= 1'b0;
      else       timeout_q <= expire;
   end

   assign o_timeout = timeout_q;
`else
   assign expire    = 1'b0;
   assign o_timeout = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      ops_d   = ops_q;
      case (state_q)
         S0: begin
            if (accept) begin
               ops_d[0] = i_data;
               state_d  = S1;
            end
         end
         S1: begin
            if (accept) begin
               ops_d[1] = i_data;
               state_d  = S2;
            end else if (expire) begin
               state_d  = S0;
            end
         end
         S2: begin
            if (accept) begin
               ops_d[2] = i_data;
               state_d  = HOLD;
            end else if (expire) begin
               state_d  = S0;
            end
         end
         HOLD: begin
            if (i_ready) state_d = S0;
         end
         default: state_d = S0;
      endcase
   end

   // Operands are left in place after handoff; only new accepts overwrite them.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= S0;
         ops_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ops_q   <= ops_d;
         valid_q <= (state_d == HOLD);
      end
   end

   assign o_p0    = ops_q[0];
   assign o_p1    = ops_q[1];
   assign o_p2    = ops_q[2];
   assign o_valid = valid_q;

endmodule

// File: tb/tb_operand_loader.sv
// Self-checking bench for operand_loader: directed scenarios plus randomized traffic
// compared every cycle against a byte-count/queue model of the loader.
module tb_operand_loader;

   localparam int DW = 8;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] data;
   logic          vld;
   logic          rdy_in;
   logic          o_ready, o_valid, o_timeout;
   logic [DW-1:0] o_p0, o_p1, o_p2;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   operand_loader dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_data    (data),
      .i_valid   (vld),
      .o_ready   (o_ready),
      .o_p0      (o_p0),
      .o_p1      (o_p1),
      .o_p2      (o_p2),
      .o_valid   (o_valid),
      .i_ready   (rdy_in),
      .o_timeout (o_timeout)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: number of bytes collected so far, the captured bytes, and whether a frame is presented.
   int            m_n     = 0;
   int            m_idle  = 0;
   bit            m_valid = 0;
   bit            m_to    = 0;
   logic [DW-1:0] m_p [3] = '{default: '0};

   always @(posedge clk) begin : model
      int            nn, ii;
      bit            vv, tt;
      logic [DW-1:0] pp [3];
      nn = m_n; ii = m_idle; vv = m_valid; tt = 0; pp = m_p;
      if (rst) begin
         nn = 0; ii = 0; vv = 0; pp = '{default: '0};
      end else if (vv) begin
         if (rdy_in) begin vv = 0; nn = 0; end
      end else if (vld) begin
         pp[nn] = data; nn++; ii = 0; vv = (nn == 3);
      end else if (nn > 0) begin
         ii++;
`ifdef OPERAND_LOADER_TIMEOUT_EN
         if (ii == TO) begin nn = 0; ii = 0; tt = 1; end
`endif
      end
      m_n <= nn; m_idle <= ii; m_valid <= vv; m_to <= tt; m_p <= pp;
   end

   always @(negedge clk) begin
      #1;
      check("o_valid",   o_valid,   m_valid);
      check("o_ready",   o_ready,   !rst && !m_valid);
      check("o_timeout", o_timeout, m_to);
      check("o_p0",      o_p0,      m_p[0]);
      check("o_p1",      o_p1,      m_p[1]);
      check("o_p2",      o_p2,      m_p[2]);
   end

   task automatic step(input logic v, input logic [DW-1:0] d, input logic r);
      @(negedge clk);
      rst = 1'b0; vld = v; data = d; rdy_in = r;
   endtask

   task automatic chk_frame(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input logic [DW-1:0] c);
      #2;
      check({tag, "_valid"}, o_valid, 1'b1);
      check({tag, "_p0"}, o_p0, a);
      check({tag, "_p1"}, o_p1, b);
      check({tag, "_p2"}, o_p2, c);
   endtask

   initial begin
      int vp;
      rst = 1'b1; vld = 1'b1; data = 8'h5a; rdy_in = 1'b1;

      // Reset state, with i_rst still high
      @(negedge clk); #2;
      check("rst_ready", o_ready, 1'b0);
      check("rst_valid", o_valid, 1'b0);
      check("rst_p0",    o_p0,    8'h00);

      // Back-to-back bytes, next frame starts 4 cycles after the first byte
      step(1, 8'h0f, 1); step(1, 8'h55, 1); step(1, 8'h88, 1);
      step(0, 8'h00, 1); chk_frame("f1", 8'h0f, 8'h55, 8'h88);
      check("f1_hold_ready", o_ready, 1'b0);
      step(1, 8'haa, 1); #2; check("f2_ready_4cyc", o_ready, 1'b1);
      step(1, 8'hbb, 1); step(1, 8'hcc, 1);
      step(0, 8'h00, 1); chk_frame("f2", 8'haa, 8'hbb, 8'hcc);

      // Downstream stall; ee offered during HOLD must not be captured
      step(1, 8'h74, 1); step(1, 8'h81, 1); step(1, 8'h11, 0);
      for (int i = 0; i < 5; i++) begin
         step(1, 8'hee, 0);
         if (i == 0 || i == 4) begin
            chk_frame("stall", 8'h74, 8'h81, 8'h11);
            check("stall_ready", o_ready, 1'b0);
         end
      end
      step(1, 8'hee, 1);
      step(0, 8'h00, 1); #2;
      check("stall_rel_valid", o_valid, 1'b0);
      check("stall_retain_p0", o_p0, 8'h74);
      check("stall_retain_p2", o_p2, 8'h11);

      // Gapped input
      foreach (m_p[k]) begin
         step(1, DW'(k + 1), 1); step(0, 8'h00, 1); step(0, 8'h00, 1);
         if (k == 2) begin
            @(negedge clk);
         end
      end
      step(1, 8'h01, 0); step(1, 8'h02, 0); step(1, 8'h03, 0);
      step(0, 8'h00, 1); chk_frame("gap2", 8'h01, 8'h02, 8'h03);

`ifdef OPERAND_LOADER_TIMEOUT_EN
      // Partial frame dropped after TO idle cycles
      step(0, 8'h00, 1);
      step(1, 8'h74, 1); step(1, 8'h81, 1);
      for (int i = 0; i < TO; i++) begin
         step(0, 8'h00, 1); #2; check("to_no_pulse_yet", o_timeout, 1'b0);
      end
      step(0, 8'h00, 1); #2;
      check("to_pulse", o_timeout, 1'b1);
      check("to_ready", o_ready, 1'b1);
      step(1, 8'h11, 1); #2; check("to_pulse_end", o_timeout, 1'b0);
      step(1, 8'h22, 1); step(1, 8'h33, 1);
      step(0, 8'h00, 1); chk_frame("to_after", 8'h11, 8'h22, 8'h33);

      // Accept on the last idle cycle wins
      step(1, 8'h74, 1); step(1, 8'h81, 1);
      for (int i = 0; i < TO - 1; i++) step(0, 8'h00, 1);
      step(1, 8'h11, 1);
      step(0, 8'h00, 1); chk_frame("to_race", 8'h74, 8'h81, 8'h11);
      check("to_race_no_pulse", o_timeout, 1'b0);
`else
      // Without the timeout a partial frame waits indefinitely
      step(0, 8'h00, 1);
      step(1, 8'h74, 1); step(1, 8'h81, 1);
      for (int i = 0; i < TO + 4; i++) step(0, 8'h00, 1);
      #2; check("no_to_pulse", o_timeout, 1'b0);
      step(1, 8'h11, 1);
      step(0, 8'h00, 1); chk_frame("no_to", 8'h74, 8'h81, 8'h11);
`endif

      // Reset mid-frame discards the frame
      step(0, 8'h00, 1);
      step(1, 8'haa, 1);
      @(negedge clk); rst = 1'b1; vld = 1'b1; data = 8'h55; #2;
      check("mid_rst_ready", o_ready, 1'b0);
      @(negedge clk); rst = 1'b0; vld = 1'b0; #2;
      check("mid_rst_p0",    o_p0,      8'h00);
      check("mid_rst_valid", o_valid,   1'b0);
      check("mid_rst_to",    o_timeout, 1'b0);
      step(1, 8'h0f, 1); step(1, 8'h55, 1); step(1, 8'h88, 1);
      step(0, 8'h00, 1); chk_frame("post_rst", 8'h0f, 8'h55, 8'h88);

      // Randomized traffic with varying input density
      vp = 80;
      for (int i = 0; i < 600; i++) begin
         if (i % 60 == 0) vp = (vp == 80) ? 30 : (vp == 30) ? 4 : 80;
         @(negedge clk);
         rst    = ($urandom_range(0, 199) == 0);
         vld    = ($urandom_range(0, 99) < vp);
         data   = DW'($urandom);
         rdy_in = ($urandom_range(0, 99) < 60);
      end

      step(0, 8'h00, 1);
      @(negedge clk); #2;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
